// File: rtl/controlpath_mc_pkg.sv
// Shared definitions for the multi-cycle control path: FSM state encoding,
// instruction class codes and the bit positions of every instruction field.
package controlpath_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALTED    = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam logic [3:0] CLS_NOP  = 4'h0;
  localparam logic [3:0] CLS_ALU  = 4'h1;
  localparam logic [3:0] CLS_ALUI = 4'h2;
  localparam logic [3:0] CLS_HALT = 4'hF;

  // Field positions within the low 32 bits of the instruction word.
  localparam int CLS_MSB   = 31;
  localparam int CLS_LSB   = 28;
  localparam int OP_MSB    = 27;
  localparam int OP_LSB    = 25;
  localparam int FORM_BIT  = 24;
  localparam int PERCI_MSB = 23;
  localparam int PERCI_LSB = 22;
  localparam int Y_MSB     = 21;
  localparam int Y_LSB     = 18;
  localparam int A_MSB     = 17;
  localparam int A_LSB     = 14;
  localparam int B_MSB     = 13;
  localparam int B_LSB     = 10;
  localparam int MASK_LSB  = 8;
  localparam int IMM_MSB   = 13;
  localparam int IMM_LSB   = 0;

endpackage

// File: rtl/controlpath_mc_if.sv
// Bus between the instruction source / datapath and the control path.
//
// Handshake: an instruction transfers on every rising clk edge where
// instr_valid && instr_ready are both high. The source holds instr_valid and
// instruction stable until that edge; instr_ready never depends on
// instr_valid. All other outputs of the control path are registered.
interface controlpath_mc_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 4,
  parameter int WRITE_PORTS = 2
);
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   stall;
  logic                   resume;
  logic                   alu_start;
  logic [2:0]             alu_op;
  logic                   alu_form;
  logic [1:0]             alu_vec_perci;
  logic                   const_c;
  logic [DATA_WIDTH-1:0]  constant;
  logic [SEL_WIDTH-1:0]   alu_a_select;
  logic [SEL_WIDTH-1:0]   alu_b_select;
  logic [SEL_WIDTH-1:0]   alu_y_select;
  logic [WRITE_PORTS-1:0] alu_write;
  logic                   program_counter_inc;
  logic                   halted;
  logic                   fault;

  modport master (
    output instr_valid, instruction, stall, resume,
    input  instr_ready, alu_start, alu_op, alu_form, alu_vec_perci, const_c,
           constant, alu_a_select, alu_b_select, alu_y_select, alu_write,
           program_counter_inc, halted, fault
  );

  modport slave (
    input  instr_valid, instruction, stall, resume,
    output instr_ready, alu_start, alu_op, alu_form, alu_vec_perci, const_c,
           constant, alu_a_select, alu_b_select, alu_y_select, alu_write,
           program_counter_inc, halted, fault
  );
endinterface

// File: rtl/controlpath_mc_cp_field_decode.sv
// Purely combinational field decoder: latched instruction word -> control
// bundle, class flags and an invalid-class flag.
module cp_field_decode
  import controlpath_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 4,
  parameter int WRITE_PORTS = 2
) (
  input  logic [INSTR_WIDTH-1:0] i_word,
  output logic [2:0]             o_op,
  output logic                   o_form,
  output logic [1:0]             o_perci,
  output logic                   o_const_c,
  output logic [DATA_WIDTH-1:0]  o_constant,
  output logic [SEL_WIDTH-1:0]   o_a_sel,
  output logic [SEL_WIDTH-1:0]   o_b_sel,
  output logic [SEL_WIDTH-1:0]   o_y_sel,
  output logic [WRITE_PORTS-1:0] o_mask,
  output logic                   o_is_alu,
  output logic                   o_is_nop,
  output logic                   o_is_halt,
  output logic                   o_invalid
);

  logic [3:0]             w_class;
  logic [WRITE_PORTS-1:0] w_mask;
  logic                   w_unused;

  assign w_class = i_word[CLS_MSB:CLS_LSB];
  // Mask bits at or above WRITE_PORTS are simply not selected.
  assign w_mask  = i_word[MASK_LSB +: WRITE_PORTS];
  // Reserved bits [7:0] and anything above bit 31 carry no meaning.
  assign w_unused = ^i_word;

  // Raw fields by default; class-specific overrides for immediate and mask.
  always_comb begin
    o_op       = i_word[OP_MSB:OP_LSB];
    o_form     = i_word[FORM_BIT];
    o_perci    = i_word[PERCI_MSB:PERCI_LSB];
    o_y_sel    = SEL_WIDTH'(i_word[Y_MSB:Y_LSB]);
    o_a_sel    = SEL_WIDTH'(i_word[A_MSB:A_LSB]);
    o_b_sel    = SEL_WIDTH'(i_word[B_MSB:B_LSB]);
    o_const_c  = 1'b0;
    o_constant = '0;
    o_mask     = '0;
    o_is_alu   = 1'b0;
    o_is_nop   = 1'b0;
    o_is_halt  = 1'b0;
    o_invalid  = 1'b0;
    case (w_class)
      CLS_ALU: begin
        o_is_alu = 1'b1;
        o_mask   = w_mask;
      end
      CLS_ALUI: begin
        o_is_alu   = 1'b1;
        o_mask     = w_mask;
        o_const_c  = 1'b1;
        // The immediate shares bits with the b field, so b is forced to 0.
        o_constant = DATA_WIDTH'($signed(i_word[IMM_MSB:IMM_LSB]));
        o_b_sel    = '0;
      end
      CLS_NOP:  o_is_nop  = 1'b1;
      CLS_HALT: o_is_halt = 1'b1;
      default:  o_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/controlpath_mc.sv
// Multi-cycle control path: fetches an instruction over valid/ready, decodes
// it for one cycle, holds EXECUTE for ALU_LATENCY cycles (stallable), then
// pulses the write enables and the PC increment. HALT can be resumed; an
// invalid class latches FAULT until reset.
// Parameter constraints: INSTR_WIDTH >= 32, ALU_LATENCY >= 1,
// WRITE_PORTS in 1..2, DATA_WIDTH >= 14.
module controlpath_mc
  import controlpath_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 4,
  parameter int WRITE_PORTS = 2,
  parameter int ALU_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  controlpath_mc_if.slave bus,
  output state_t          o_dbg_state
);

  localparam int               CNT_W    = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);

  state_t                 r_state, w_next_state;
  logic [CNT_W-1:0]       r_cnt, w_cnt_next;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   w_instr_ready, w_accept, w_wb_fire;

  logic [2:0]             w_dec_op;
  logic                   w_dec_form;
  logic [1:0]             w_dec_perci;
  logic                   w_dec_const_c;
  logic [DATA_WIDTH-1:0]  w_dec_constant;
  logic [SEL_WIDTH-1:0]   w_dec_a_sel, w_dec_b_sel, w_dec_y_sel;
  logic [WRITE_PORTS-1:0] w_dec_mask;
  logic                   w_dec_is_alu, w_dec_is_nop, w_dec_is_halt, w_dec_invalid;

  logic [2:0]             r_alu_op;
  logic                   r_alu_form;
  logic [1:0]             r_alu_vec_perci;
  logic                   r_const_c;
  logic [DATA_WIDTH-1:0]  r_constant;
  logic [SEL_WIDTH-1:0]   r_a_sel, r_b_sel, r_y_sel;
  logic [WRITE_PORTS-1:0] r_mask;
  logic [WRITE_PORTS-1:0] r_alu_write;
  logic                   r_alu_start, r_pc_inc, r_halted, r_fault;

  cp_field_decode #(
    .INSTR_WIDTH(INSTR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH),
    .WRITE_PORTS(WRITE_PORTS)
  ) u_decode (
    .i_word    (r_instr),
    .o_op      (w_dec_op),
    .o_form    (w_dec_form),
    .o_perci   (w_dec_perci),
    .o_const_c (w_dec_const_c),
    .o_constant(w_dec_constant),
    .o_a_sel   (w_dec_a_sel),
    .o_b_sel   (w_dec_b_sel),
    .o_y_sel   (w_dec_y_sel),
    .o_mask    (w_dec_mask),
    .o_is_alu  (w_dec_is_alu),
    .o_is_nop  (w_dec_is_nop),
    .o_is_halt (w_dec_is_halt),
    .o_invalid (w_dec_invalid)
  );

  // Ready is a state decode, masked during reset so nothing is taken then.
  assign w_instr_ready = (r_state == S_FETCH) && !reset;
  assign w_accept      = w_instr_ready && bus.instr_valid;
  assign w_wb_fire     = (r_state == S_WRITEBACK) && !bus.stall;

  // Next-state and latency-counter logic.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_FETCH: if (w_accept) w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_dec_invalid)      w_next_state = S_FAULT;
        else if (w_dec_is_halt) w_next_state = S_HALTED;
        else if (w_dec_is_nop)  w_next_state = S_WRITEBACK;
        else if (w_dec_is_alu) begin
          w_next_state = S_EXECUTE;
          w_cnt_next   = CNT_LOAD;
        end else                w_next_state = S_FAULT;
      end
      S_EXECUTE: begin
        if (!bus.stall) begin
          if (r_cnt == '0) w_next_state = S_WRITEBACK;
          else             w_cnt_next   = r_cnt - 1'b1;
        end
      end
      S_WRITEBACK: if (!bus.stall)  w_next_state = S_FETCH;
      S_HALTED:    if (bus.resume)  w_next_state = S_FETCH;
      S_FAULT:     w_next_state = S_FAULT;
      default:     w_next_state = S_FETCH;
    endcase
  end

  // State, counter and instruction latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (w_accept) r_instr <= bus.instruction;
    end
  end

  // Registered outputs: pulses, status flags and the control bundle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_start     <= 1'b0;
      r_alu_write     <= '0;
      r_pc_inc        <= 1'b0;
      r_halted        <= 1'b0;
      r_fault         <= 1'b0;
      r_alu_op        <= '0;
      r_alu_form      <= 1'b0;
      r_alu_vec_perci <= '0;
      r_const_c       <= 1'b0;
      r_constant      <= '0;
      r_a_sel         <= '0;
      r_b_sel         <= '0;
      r_y_sel         <= '0;
      r_mask          <= '0;
    end else begin
      r_alu_start <= (r_state == S_DECODE) && (w_next_state == S_EXECUTE);
      r_alu_write <= w_wb_fire ? r_mask : '0;
      r_pc_inc    <= w_wb_fire;
      r_halted    <= (w_next_state == S_HALTED);
      r_fault     <= (w_next_state == S_FAULT);
      if (r_state == S_DECODE) begin
        r_alu_op        <= w_dec_op;
        r_alu_form      <= w_dec_form;
        r_alu_vec_perci <= w_dec_perci;
        r_const_c       <= w_dec_const_c;
        r_constant      <= w_dec_constant;
        r_a_sel         <= w_dec_a_sel;
        r_b_sel         <= w_dec_b_sel;
        r_y_sel         <= w_dec_y_sel;
        r_mask          <= w_dec_mask;
      end
    end
  end

  assign bus.instr_ready         = w_instr_ready;
  assign bus.alu_start           = r_alu_start;
  assign bus.alu_op              = r_alu_op;
  assign bus.alu_form            = r_alu_form;
  assign bus.alu_vec_perci       = r_alu_vec_perci;
  assign bus.const_c             = r_const_c;
  assign bus.constant            = r_constant;
  assign bus.alu_a_select        = r_a_sel;
  assign bus.alu_b_select        = r_b_sel;
  assign bus.alu_y_select        = r_y_sel;
  assign bus.alu_write           = r_alu_write;
  assign bus.program_counter_inc = r_pc_inc;
  assign bus.halted              = r_halted;
  assign bus.fault               = r_fault;
  assign o_dbg_state             = r_state;

endmodule

// File: tb/tb_controlpath_mc.sv
// Directed bench for controlpath_mc with ALU_LATENCY = 3.
module tb_controlpath_mc;
  import controlpath_pkg::*;

  localparam int LAT = 3;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  controlpath_mc_if #(.INSTR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .WRITE_PORTS(2)) bus ();

  controlpath_mc #(
    .INSTR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .WRITE_PORTS(2), .ALU_LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Per-scenario pulse bookkeeping, cycle 0 = the cycle counts were cleared.
  int         cyc;
  int         idx_start, idx_wr, idx_pc;
  int         n_start, n_wr, n_pc, n_halt, n_rdy;
  logic [1:0] wr_val;
  logic [1:0] exp_q[$];

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    cyc = 0; idx_start = -1; idx_wr = -1; idx_pc = -1;
    n_start = 0; n_wr = 0; n_pc = 0; n_halt = 0; n_rdy = 0; wr_val = '0;
  endtask

  task automatic step();
    tick();
    cyc++;
    if (bus.alu_start) begin n_start++; if (idx_start < 0) idx_start = cyc; end
    if (bus.alu_write != '0) begin n_wr++; if (idx_wr < 0) begin idx_wr = cyc; wr_val = bus.alu_write; end end
    if (bus.program_counter_inc) begin n_pc++; if (idx_pc < 0) idx_pc = cyc; end
    if (bus.halted) n_halt++;
    if (bus.instr_ready) n_rdy++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present a word and hold valid until it is taken; returns in DECODE.
  task automatic send(input logic [31:0] w);
    int k;
    k = 0;
    bus.instruction = w;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && k < 50) begin tick(); k++; end
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_total++; if (bus.instr_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", bus.instr_ready); else n_pass++;
    n_total++; if (dbg_state !== S_FETCH) $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_FETCH); else n_pass++;
    n_total++;
    if ({bus.alu_start, bus.alu_write, bus.program_counter_inc, bus.halted, bus.fault, bus.const_c} !== 7'd0 ||
        bus.constant !== 32'd0 || bus.alu_op !== 3'd0 || bus.alu_y_select !== 4'd0)
      $display("FAIL rst_outputs got start=%b wr=%b pc=%b h=%b f=%b c=%h exp all zero",
               bus.alu_start, bus.alu_write, bus.program_counter_inc, bus.halted, bus.fault, bus.constant);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (bus.instr_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", bus.instr_ready); else n_pass++;
  endtask

  // 0x1A2C4300: class 1, op 5, form 0, perci 0, y=[21:18]=0xB, a=1, b=0, mask 11.
  task automatic test_alu();
    send(32'h1A2C_4300);
    n_total++; if (dbg_state !== S_DECODE) $display("FAIL alu_decode_state got=%0d exp=%0d", dbg_state, S_DECODE); else n_pass++;
    clear_counts();
    run(8);
    n_total++; if (bus.alu_op !== 3'd5) $display("FAIL alu_op got=%0d exp=5", bus.alu_op); else n_pass++;
    n_total++; if (bus.alu_y_select !== 4'hB) $display("FAIL alu_y got=%h exp=b", bus.alu_y_select); else n_pass++;
    n_total++; if (bus.alu_a_select !== 4'h1) $display("FAIL alu_a got=%h exp=1", bus.alu_a_select); else n_pass++;
    n_total++; if (bus.alu_b_select !== 4'h0) $display("FAIL alu_b got=%h exp=0", bus.alu_b_select); else n_pass++;
    n_total++; if (bus.const_c !== 1'b0 || bus.constant !== 32'd0) $display("FAIL alu_const got=%b/%h exp=0/0", bus.const_c, bus.constant); else n_pass++;
    n_total++; if (n_start !== 1 || idx_start !== 1) $display("FAIL alu_start got n=%0d idx=%0d exp n=1 idx=1", n_start, idx_start); else n_pass++;
    n_total++; if (n_wr !== 1 || idx_wr !== LAT + 2 || wr_val !== 2'b11) $display("FAIL alu_write got n=%0d idx=%0d val=%b exp n=1 idx=5 val=11", n_wr, idx_wr, wr_val); else n_pass++;
    n_total++; if (n_pc !== 1 || idx_pc !== LAT + 2) $display("FAIL alu_pc got n=%0d idx=%0d exp n=1 idx=5", n_pc, idx_pc); else n_pass++;
  endtask

  task automatic test_alui();
    send(32'h2000_3FFF);
    clear_counts();
    run(5);
    n_total++; if (bus.constant !== 32'hFFFF_FFFF) $display("FAIL alui_neg_const got=%h exp=ffffffff", bus.constant); else n_pass++;
    n_total++; if (bus.const_c !== 1'b1 || bus.alu_b_select !== 4'h0) $display("FAIL alui_neg_cb got=%b/%h exp=1/0", bus.const_c, bus.alu_b_select); else n_pass++;
    n_total++; if (idx_wr !== 5 || wr_val !== 2'b11) $display("FAIL alui_neg_wr got idx=%0d val=%b exp idx=5 val=11", idx_wr, wr_val); else n_pass++;
    send(32'h2000_1FFF);
    clear_counts();
    run(5);
    n_total++; if (bus.constant !== 32'h0000_1FFF) $display("FAIL alui_pos_const got=%h exp=00001fff", bus.constant); else n_pass++;
    n_total++; if (bus.const_c !== 1'b1 || bus.alu_b_select !== 4'h0) $display("FAIL alui_pos_cb got=%b/%h exp=1/0", bus.const_c, bus.alu_b_select); else n_pass++;
  endtask

  task automatic test_nop_fault();
    send(32'h0000_0300);
    clear_counts();
    run(2);
    n_total++; if (n_pc !== 1 || idx_pc !== 2 || n_wr !== 0) $display("FAIL nop_pulse got pc=%0d idx=%0d wr=%0d exp pc=1 idx=2 wr=0", n_pc, idx_pc, n_wr); else n_pass++;
    n_total++; if (dbg_state !== S_FETCH) $display("FAIL nop_state got=%0d exp=%0d", dbg_state, S_FETCH); else n_pass++;
    send(32'h7000_0000);
    clear_counts();
    run(4);
    n_total++; if (bus.fault !== 1'b1 || dbg_state !== S_FAULT) $display("FAIL fault_set got f=%b st=%0d exp f=1 st=%0d", bus.fault, dbg_state, S_FAULT); else n_pass++;
    n_total++; if (n_pc !== 0 || n_wr !== 0 || n_rdy !== 0) $display("FAIL fault_quiet got pc=%0d wr=%0d rdy=%0d exp 0/0/0", n_pc, n_wr, n_rdy); else n_pass++;
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    step();
    n_total++; if (bus.fault !== 1'b1 || bus.instr_ready !== 1'b0) $display("FAIL fault_resume got f=%b rdy=%b exp f=1 rdy=0", bus.fault, bus.instr_ready); else n_pass++;
    reset = 1'b1;
    tick();
    n_total++; if (bus.fault !== 1'b0 || dbg_state !== S_FETCH) $display("FAIL fault_reset got f=%b st=%0d exp f=0 st=%0d", bus.fault, dbg_state, S_FETCH); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (bus.instr_ready !== 1'b1) $display("FAIL fault_reset_ready got=%b exp=1", bus.instr_ready); else n_pass++;
  endtask

  task automatic test_halt();
    send(32'hF000_0000);
    clear_counts();
    run(5);
    n_total++; if (n_halt !== 5 || n_rdy !== 0) $display("FAIL halt_hold got halted=%0d rdy=%0d exp 5/0", n_halt, n_rdy); else n_pass++;
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    n_total++; if (bus.instr_ready !== 1'b1 || bus.halted !== 1'b0) $display("FAIL halt_resume got rdy=%b h=%b exp rdy=1 h=0", bus.instr_ready, bus.halted); else n_pass++;
    run(2);
    n_total++; if (n_pc !== 0 || n_wr !== 0) $display("FAIL halt_no_pc got pc=%0d wr=%0d exp 0/0", n_pc, n_wr); else n_pass++;
  endtask

  task automatic test_stall();
    send(32'h1A2C_4300);
    clear_counts();
    step();
    bus.stall = 1'b1;
    run(2);
    bus.stall = 1'b0;
    run(3);
    n_total++; if (dbg_state !== S_WRITEBACK) $display("FAIL stall_ex_state got=%0d exp=%0d", dbg_state, S_WRITEBACK); else n_pass++;
    bus.stall = 1'b1;
    run(2);
    n_total++; if (dbg_state !== S_WRITEBACK || n_wr !== 0 || n_pc !== 0) $display("FAIL stall_wb_hold got st=%0d wr=%0d pc=%0d exp st=%0d 0/0", dbg_state, n_wr, n_pc, S_WRITEBACK); else n_pass++;
    bus.stall = 1'b0;
    run(3);
    n_total++; if (idx_wr !== LAT + 2 + 4 || n_wr !== 1 || n_pc !== 1 || idx_pc !== LAT + 6) $display("FAIL stall_done got wr_idx=%0d n_wr=%0d n_pc=%0d pc_idx=%0d exp 9/1/1/9", idx_wr, n_wr, n_pc, idx_pc); else n_pass++;
    n_total++; if (n_start !== 1) $display("FAIL stall_start got=%0d exp=1", n_start); else n_pass++;
  endtask

  task automatic test_reset_exec();
    send(32'h1A2C_4300);
    clear_counts();
    run(2);
    reset = 1'b1;
    #1;
    n_total++; if (bus.instr_ready !== 1'b0) $display("FAIL rex_ready_in_reset got=%b exp=0", bus.instr_ready); else n_pass++;
    step();
    n_total++;
    if (bus.alu_write !== 2'b00 || bus.program_counter_inc !== 1'b0 || bus.alu_start !== 1'b0 ||
        bus.alu_op !== 3'd0 || bus.alu_y_select !== 4'd0 || bus.alu_a_select !== 4'd0 || bus.halted !== 1'b0 || bus.fault !== 1'b0)
      $display("FAIL rex_outputs got wr=%b pc=%b op=%0d y=%h a=%h exp all zero", bus.alu_write, bus.program_counter_inc, bus.alu_op, bus.alu_y_select, bus.alu_a_select);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (bus.instr_ready !== 1'b1) $display("FAIL rex_ready got=%b exp=1", bus.instr_ready); else n_pass++;
    run(8);
    n_total++; if (n_wr !== 0 || n_pc !== 0) $display("FAIL rex_abort got wr=%0d pc=%0d exp 0/0", n_wr, n_pc); else n_pass++;
  endtask

  // 0x1FC91500: op 7, form 1, perci 3, y 2, a 4, b 5, mask 01; then 0x10000200 mask 10.
  task automatic test_back_to_back();
    exp_q.delete();
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    clear_counts();
    bus.instruction = 32'h1FC9_1500;
    bus.instr_valid = 1'b1;
    step();
    bus.instruction = 32'h1000_0200;
    step();
    n_total++;
    if (bus.alu_op !== 3'd7 || bus.alu_form !== 1'b1 || bus.alu_vec_perci !== 2'd3 ||
        bus.alu_y_select !== 4'd2 || bus.alu_a_select !== 4'd4 || bus.alu_b_select !== 4'd5)
      $display("FAIL b2b_bundle got op=%0d f=%b p=%0d y=%0d a=%0d b=%0d exp 7/1/3/2/4/5", bus.alu_op, bus.alu_form, bus.alu_vec_perci, bus.alu_y_select, bus.alu_a_select, bus.alu_b_select);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cyc == 7) bus.instr_valid = 1'b0;
      if (bus.alu_write != 2'b00) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra_write got=%b exp none", bus.alu_write);
        else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if (bus.alu_write !== e) $display("FAIL b2b_write got=%b exp=%b", bus.alu_write, e); else n_pass++;
        end
      end
    end
    n_total++; if (exp_q.size() != 0) $display("FAIL b2b_missing_writes got left=%0d exp=0", exp_q.size()); else n_pass++;
    n_total++; if (n_pc !== 2 || idx_pc !== LAT + 3) $display("FAIL b2b_period got pc=%0d first=%0d exp 2/6", n_pc, idx_pc); else n_pass++;
  endtask

  initial begin
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.stall       = 1'b0;
    bus.resume      = 1'b0;
    test_reset();
    test_alu();
    test_alui();
    test_nop_fault();
    test_halt();
    test_stall();
    test_reset_exec();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
